// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and delivered-instruction counter.
// Instruction memory is zero-wait combinational; instrF answers pcF in the same cycle.
module fetch_unit #(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0]  NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stallF,
  input  logic         stallD,
  input  logic         flushD,
  input  logic         pcSrcE,
  input  logic [W-1:0] pcTargetE,
  input  logic [31:0]  instrF,
  output logic [W-1:0] pcF,
  output logic [W-1:0] pcPlus4F,
  output logic [31:0]  instrD,
  output logic [W-1:0] pcD,
  output logic [W-1:0] pcPlus4D,
  output logic         validD,
  output logic         misalignD,
  output logic [31:0]  fetchCount
);

  function automatic logic is_misaligned(input logic [W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [W-1:0] addr, input logic [31:0] word);
    return is_misaligned(addr) ? NOP : word;
  endfunction

  logic load_d;

  assign pcPlus4F = pcF + W'(4);
  assign load_d   = !flushD && !stallD;

  // IF stage: a redirect wins over stallF so a resolved branch is never dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF <= RESET_PC;
    end else if (pcSrcE) begin
      pcF <= pcTargetE;
    end else if (!stallF) begin
      pcF <= pcPlus4F;
    end
  end

  // IF/ID boundary: flush inserts a bubble even while decode is stalled
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      instrD    <= NOP;
      pcD       <= '0;
      pcPlus4D  <= '0;
      validD    <= 1'b0;
      misalignD <= 1'b0;
    end else if (load_d) begin
      instrD    <= fetch_word(pcF, instrF);
      pcD       <= pcF;
      pcPlus4D  <= pcPlus4F;
      validD    <= 1'b1;
      misalignD <= is_misaligned(pcF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCount <= '0;
    end else if (load_d) begin
      fetchCount <= fetchCount + 32'd1;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RV32I pipeline. It holds the program counter, drives the instruction memory address (`pcF`), and takes back the fetched word (`instrF`) in the same cycle. It registers the word into the IF/ID pipeline register for decode. It also applies stall, flush and branch-redirect control from the hazard unit and execute stage, and flags misaligned fetch addresses.

## Interface
Parameters:
- `W` — 32 — address/data width
- `RESET_PC` — 32'h0000_0000 — PC value after reset
- `NOP` — 32'h0000_0013 — bubble encoding (`addi x0,x0,0`)

Ports:
- `clk`  in  1  — clock; all state updates on rising edge
- `rst`  in  1  — synchronous, active-high reset
- `stallF`  in  1  — hold PC
- `stallD`  in  1  — hold IF/ID register
- `flushD`  in  1  — replace IF/ID contents with bubble
- `pcSrcE`  in  1  — taken branch/jump resolved in execute
- `pcTargetE`  in  W  — redirect target
- `instrF`  in  32  — word returned by instruction memory for `pcF` (combinational)
- `pcF`  out  W  — registered PC, instruction memory address
- `pcPlus4F`  out  W  — `pcF + 4`, combinational
- `instrD`  out  32  — registered instruction for decode
- `pcD`, `pcPlus4D`  out  W  — registered PC and PC+4 of `instrD`
- `validD`  out  1  — `instrD` is a real fetched instruction, not a bubble
- `misalignD`  out  1  — `pcD[1:0] != 0`; decode raises an instruction-address-misaligned trap
- `fetchCount`  out  32  — number of valid instructions delivered to decode

## Operation
- PC register update, highest priority first:
  - `rst`: `pcF <= RESET_PC`.
  - `pcSrcE`: `pcF <= pcTargetE`. This overrides `stallF`, so a redirect is never lost.
  - `stallF`: hold.
  - Otherwise: `pcF <= pcPlus4F`.
- `pcPlus4F = pcF + 4` modulo 2^W. 32'hFFFF_FFFC wraps to 0 with no flag.
- IF/ID register update, highest priority first:
  - `rst`: `instrD=NOP`, `pcD=0`, `pcPlus4D=0`, `validD=0`, `misalignD=0`.
  - `flushD`: same values as reset. This overrides `stallD`.
  - `stallD`: hold all fields.
  - Otherwise, load `pcD=pcF`, `pcPlus4D=pcPlus4F`, `validD=1`, `misalignD=(pcF[1:0]!=0)`. `instrD` gets `instrF`, or `NOP` if misaligned.
- `fetchCount`:
  - Resets to 0.
  - Increments by 1 on each edge where the IF/ID load path (neither `rst`, `flushD` nor `stallD`) is taken.
  - Wraps 32'hFFFF_FFFF to 0.
  - A misaligned load still counts.
- `stallF` and `stallD` are independent inputs. The hazard unit normally asserts them together; the block does not enforce that.
- No state machine beyond the PC and IF/ID registers. The block has no handshake with memory; memory is treated as zero-wait combinational.

## Timing
- `pcF` changes only on rising `clk`. `instrF` is sampled at the same edge that advances `pcF`.
- Fetch-to-decode latency is 1 cycle: the word at `pcF` in cycle n appears on `instrD` in cycle n+1.
- Redirect latency is 1 cycle: `pcSrcE=1` in cycle n gives `pcF=pcTargetE` in cycle n+1.
  - Squashing the wrong-path words already in IF/ID and ID/EX is the hazard unit's job, via `flushD` and the execute flush.
- With `pcSrcE`, `stallF` and `flushD` all high in one cycle, three things happen at that edge: the PC takes the target, IF/ID becomes a bubble, and `fetchCount` is unchanged.
- Reset asserted mid-run takes effect at the next edge regardless of the other inputs. The first fetch after deassertion is at `RESET_PC`.
- All outputs except `pcPlus4F` are registered.

## Test plan
- Reset, then free-run 4 cycles with no control: `pcF` runs 0, 4, 8, 12. `instrD` trails by one cycle with `validD=1`, `pcD` = 0, 4, 8. `fetchCount` = 3 after the 4th edge.
- `stallF=stallD=1` for 2 cycles at `pcF`=8: `pcF` stays 8 and `instrD`/`pcD`=4 are held. `fetchCount` does not increment. After release, `pcF` = 12.
- `pcSrcE=1`, `pcTargetE`=0x100, `flushD=1`, `stallF=1` at `pcF`=0x20: next cycle `pcF`=0x100, `instrD`=0x00000013, `validD`=0, `pcD`=0.
- `pcTargetE`=0x102 redirect, then free-run one cycle: `pcD`=0x102, `misalignD`=1, `instrD`=NOP, `validD`=1, `fetchCount`+1.
- Force `pcF` to 0xFFFF_FFFC via redirect and run 2 cycles: `pcF` wraps to 0 and `pcPlus4D`=0. Separately, preload `fetchCount` at 0xFFFF_FFFF, load one valid instruction, and confirm `fetchCount`=0.
- Assert `rst` mid-stream with `stallD=1`: next edge gives `pcF`=`RESET_PC`, `validD`=0, `fetchCount`=0.
